// File: rtl/mem_access.sv
// mem_access: PikaRISC memory stage; load/store req/ack handshake with timeout, registered writeback fields.
// Optional alignment check enabled by defining MEMACCESS_ALIGN_CHECK_EN.
module mem_access #(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [3:0]  in_rd_num,
   input  logic [31:0] in_md,
   input  logic [31:0] in_result,
   input  logic [31:0] in_cpsr,
   input  logic        in_is_alu_op,
   input  logic        in_is_cmp_op,
   input  logic        in_is_ld_op,
   input  logic        in_is_str_op,
   output logic        stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic [3:0]  rd_num_passthrough,
   output logic [31:0] md_passthrough,
   output logic [31:0] result,
   output logic [31:0] cpsr_passthrough,
   output logic [31:0] dmem_val_passthrough,
   output logic        is_alu_op_passthrough,
   output logic        is_cmp_op_passthrough,
   output logic        is_ld_op_passthrough,
   output logic        mem_fault
);
   typedef enum logic {IDLE, WAIT} state_t;
   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
   logic [3:0]  pend_rd_q, pend_rd_d, rd_q, rd_d;
   logic [31:0] md_q, md_d, res_q, res_d, cpsr_q, cpsr_d, dval_q, dval_d;
   logic        alu_q, alu_d, cmp_q, cmp_d, ld_q, ld_d, fault_q, fault_d;
   logic        dec_ld, dec_cmp, dec_alu, dec_mem, misal;
   assign dec_ld  = in_is_ld_op;
   assign dec_mem = in_is_ld_op | in_is_str_op;
   assign dec_cmp = ~dec_mem & in_is_cmp_op;
   assign dec_alu = ~dec_mem & ~in_is_cmp_op & in_is_alu_op;
`ifdef MEMACCESS_ALIGN_CHECK_EN
   assign misal = in_result[1:0] != 2'b00;
`else
   assign misal = 1'b0;
`endif
   assign stall                 = state_q == WAIT;
   assign dmem_req              = state_q == WAIT;
   assign dmem_we               = we_q;
   assign dmem_addr             = addr_q;
   assign dmem_wdata            = wdata_q;
   assign rd_num_passthrough    = rd_q;
   assign md_passthrough        = md_q;
   assign result                = res_q;
   assign cpsr_passthrough      = cpsr_q;
   assign dmem_val_passthrough  = dval_q;
   assign is_alu_op_passthrough = alu_q;
   assign is_cmp_op_passthrough = cmp_q;
   assign is_ld_op_passthrough  = ld_q;
   assign mem_fault             = fault_q;
   // Next state: accept in IDLE, resolve ack or timeout in WAIT; flags and fault default to a bubble.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      pend_rd_d = pend_rd_q;
      rd_d      = rd_q;
      md_d      = md_q;
      res_d     = res_q;
      cpsr_d    = cpsr_q;
      dval_d    = dval_q;
      alu_d     = 1'b0;
      cmp_d     = 1'b0;
      ld_d      = 1'b0;
      fault_d   = 1'b0;
      if (state_q == IDLE) begin
         if (in_valid && dec_mem && misal) begin
            fault_d = 1'b1;
         end else if (in_valid && dec_mem) begin
            state_d   = WAIT;
            cnt_d     = 8'd0;
            addr_d    = in_result;
            wdata_d   = in_md;
            we_d      = ~dec_ld;
            pend_rd_d = in_rd_num;
         end else if (in_valid && (dec_cmp || dec_alu)) begin
            rd_d   = in_rd_num;
            md_d   = in_md;
            res_d  = in_result;
            cpsr_d = in_cpsr;
            cmp_d  = dec_cmp;
            alu_d  = dec_alu;
         end
      end else if (dmem_ack) begin
         state_d = IDLE;
         if (!we_q) begin
            dval_d = dmem_rdata;
            rd_d   = pend_rd_q;
            ld_d   = 1'b1;
         end
      end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
         state_d = IDLE;
         fault_d = 1'b1;
      end else begin
         cnt_d = cnt_q == 8'hFF ? cnt_q : cnt_q + 8'd1;
      end
   end
   // State and output registers, cleared asynchronously so reset aborts any request at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         pend_rd_q <= '0;
         rd_q      <= '0;
         md_q      <= '0;
         res_q     <= '0;
         cpsr_q    <= '0;
         dval_q    <= '0;
         alu_q     <= 1'b0;
         cmp_q     <= 1'b0;
         ld_q      <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         pend_rd_q <= pend_rd_d;
         rd_q      <= rd_d;
         md_q      <= md_d;
         res_q     <= res_d;
         cpsr_q    <= cpsr_d;
         dval_q    <= dval_d;
         alu_q     <= alu_d;
         cmp_q     <= cmp_d;
         ld_q      <= ld_d;
         fault_q   <= fault_d;
      end
   end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized self-checking bench for mem_access against a transaction-level model.
module tb_mem_access;
   localparam int T = 4;
`ifdef MEMACCESS_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [3:0]  in_rd_num = '0;
   logic [31:0] in_md = '0, in_result = '0, in_cpsr = '0;
   logic        in_is_alu_op = 1'b0, in_is_cmp_op = 1'b0, in_is_ld_op = 1'b0, in_is_str_op = 1'b0;
   logic        stall, dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_ack = 1'b0;
   logic [31:0] dmem_rdata = '0;
   logic [3:0]  rd_num_passthrough;
   logic [31:0] md_passthrough, result, cpsr_passthrough, dmem_val_passthrough;
   logic        is_alu_op_passthrough, is_cmp_op_passthrough, is_ld_op_passthrough, mem_fault;
   int n_chk = 0, n_err = 0;
   logic [3:0]  e_rd = '0;
   logic [31:0] e_md = '0, e_res = '0, e_cpsr = '0, e_dval = '0;

   mem_access #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_rd_num(in_rd_num), .in_md(in_md),
      .in_result(in_result), .in_cpsr(in_cpsr), .in_is_alu_op(in_is_alu_op),
      .in_is_cmp_op(in_is_cmp_op), .in_is_ld_op(in_is_ld_op), .in_is_str_op(in_is_str_op),
      .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .rd_num_passthrough(rd_num_passthrough), .md_passthrough(md_passthrough), .result(result),
      .cpsr_passthrough(cpsr_passthrough), .dmem_val_passthrough(dmem_val_passthrough),
      .is_alu_op_passthrough(is_alu_op_passthrough), .is_cmp_op_passthrough(is_cmp_op_passthrough),
      .is_ld_op_passthrough(is_ld_op_passthrough), .mem_fault(mem_fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_flags(input logic alu, input logic cmp, input logic ld);
      chk("alu_flag", 32'(is_alu_op_passthrough), 32'(alu));
      chk("cmp_flag", 32'(is_cmp_op_passthrough), 32'(cmp));
      chk("ld_flag", 32'(is_ld_op_passthrough), 32'(ld));
   endtask

   task automatic chk_fields();
      chk("rd_num", 32'(rd_num_passthrough), 32'(e_rd));
      chk("md", md_passthrough, e_md);
      chk("result", result, e_res);
      chk("cpsr", cpsr_passthrough, e_cpsr);
      chk("dmem_val", dmem_val_passthrough, e_dval);
   endtask

   // fl = {ld, str, cmp, alu}; lat = WAIT cycle carrying ack (0 = never)
   task automatic run_op(input logic valid, input logic [3:0] fl, input logic [3:0] rd,
                         input logic [31:0] md, input logic [31:0] res, input logic [31:0] cpsr,
                         input int lat, input logic [31:0] rdata);
      logic ld, st, cm, al, mem, mis, done, acked;
      ld  = valid && fl[3];
      st  = valid && !fl[3] && fl[2];
      cm  = valid && !fl[3] && !fl[2] && fl[1];
      al  = valid && !fl[3] && !fl[2] && !fl[1] && fl[0];
      mem = ld || st;
      mis = mem && ALIGN && (res[1:0] != 2'b00);
      in_valid = valid;
      {in_is_ld_op, in_is_str_op, in_is_cmp_op, in_is_alu_op} = fl;
      in_rd_num = rd; in_md = md; in_result = res; in_cpsr = cpsr;
      dmem_ack = 1'($urandom_range(0, 1));
      dmem_rdata = $urandom;
      chk("stall_idle", 32'(stall), 32'd0);
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      if (!mem || mis) begin
         in_valid = 1'b0;
         if (cm || al) begin
            e_rd = rd; e_md = md; e_res = res; e_cpsr = cpsr;
         end
         chk_flags(al, cm, 1'b0);
         chk("fault", 32'(mem_fault), 32'(mis));
         chk("req_idle", 32'(dmem_req), 32'd0);
         chk("stall_after", 32'(stall), 32'd0);
         chk_fields();
         if (mis) begin
            @(posedge clk); #1;
            chk("fault_pulse", 32'(mem_fault), 32'd0);
         end
         return;
      end
      chk("req_start", 32'(dmem_req), 32'd1);
      chk("we", 32'(dmem_we), 32'(st));
      chk("wdata", dmem_wdata, md);
      chk_flags(1'b0, 1'b0, 1'b0);
      chk("fault_wait", 32'(mem_fault), 32'd0);
      done = 1'b0;
      for (int w = 1; w <= T && !done; w++) begin
         dmem_ack = (w == lat);
         dmem_rdata = (w == lat) ? rdata : $urandom;
         chk("req_wait", 32'(dmem_req), 32'd1);
         chk("stall_wait", 32'(stall), 32'd1);
         chk("addr_stable", dmem_addr, res);
         done = (w == lat) || (w == T);
         @(posedge clk); #1;
         dmem_ack = 1'b0;
      end
      in_valid = 1'b0;
      acked = (lat >= 1) && (lat <= T);
      if (acked && ld) begin
         e_rd = rd; e_dval = rdata;
      end
      chk_flags(1'b0, 1'b0, acked && ld);
      chk("fault_end", 32'(mem_fault), 32'(!acked));
      chk("req_end", 32'(dmem_req), 32'd0);
      chk("stall_end", 32'(stall), 32'd0);
      chk_fields();
      @(posedge clk); #1;
      chk("fault_pulse", 32'(mem_fault), 32'd0);
      chk("ld_bubble", 32'(is_ld_op_passthrough), 32'd0);
   endtask

   initial begin
      #12;
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_req", 32'(dmem_req), 32'd0);
      chk("rst_fault", 32'(mem_fault), 32'd0);
      chk_flags(1'b0, 1'b0, 1'b0);
      chk_fields();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(1'b1, 4'b0001, 4'd3, 32'h0, 32'h1234, 32'h0, 0, 32'h0);
      run_op(1'b1, 4'b1000, 4'd5, 32'h0, 32'h40, 32'h0, 3, 32'hDEADBEEF);
      run_op(1'b1, 4'b0100, 4'd6, 32'hA5A5A5A5, 32'h80, 32'h0, 1, 32'h0);
      run_op(1'b1, 4'b1000, 4'd7, 32'h0, 32'h44, 32'h0, 0, 32'h0);
      run_op(1'b1, 4'b1000, 4'd8, 32'h0, 32'h48, 32'h0, T, 32'h12345678);
      run_op(1'b1, 4'b1000, 4'd9, 32'h0, 32'h42, 32'h0, 1, 32'hCAFEF00D);
      run_op(1'b1, 4'b1111, 4'd2, 32'h0, 32'h50, 32'h0, 2, 32'h0BADC0DE);
      run_op(1'b1, 4'b0011, 4'd4, 32'h11, 32'h22, 32'h33, 0, 32'h0);
      // reset in the middle of a WAIT
      in_valid = 1'b1;
      {in_is_ld_op, in_is_str_op, in_is_cmp_op, in_is_alu_op} = 4'b1000;
      in_result = 32'h60;
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("async_req", 32'(dmem_req), 32'd0);
      chk("async_stall", 32'(stall), 32'd0);
      chk("async_fault", 32'(mem_fault), 32'd0);
      in_valid = 1'b0;
      e_rd = '0; e_md = '0; e_res = '0; e_cpsr = '0; e_dval = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk_fields();
      run_op(1'b1, 4'b0010, 4'd1, 32'h0, 32'h0, 32'h80000000, 0, 32'h0);
      for (int i = 0; i < 300; i++) begin
         run_op(1'($urandom_range(0, 5) != 0), 4'($urandom_range(0, 15)), 4'($urandom),
                $urandom, $urandom, $urandom, $urandom_range(0, T + 1), $urandom);
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
